// File: rtl/openadc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : openadc_pkg
// Description : Shared constants and FSM state encoding for the ADC front end.
// Revision    : 1.0 - initial release
// ============================================================================
package openadc_pkg;
    localparam int ADC_DATA_W     = 10;
    localparam int DECIM_MAX_LOG2 = 8;
    localparam int DECIM_K_W      = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } decim_state_t;
endpackage
`default_nettype wire

// File: rtl/decim_accum.sv
`default_nettype none
// ============================================================================
// Module      : decim_accum
// Description : Window accumulator, sticky over-range and pick/average result.
// Revision    : 1.0 - initial release
// ============================================================================
module decim_accum
    import openadc_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int MAX_LOG2 = DECIM_MAX_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 step_i,
    input  logic                 first_i,
    input  logic [DATA_W-1:0]    sample_i,
    input  logic                 or_i,
    input  logic [DECIM_K_W-1:0] k_i,
    input  logic                 mode_avg_i,
    output logic [DATA_W-1:0]    result_o,
    output logic                 sticky_o
);
    localparam int ACC_W = DATA_W + MAX_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             sticky_q, sticky_d, sticky_now;

    // Running total including the current sample; index 0 starts a fresh window.
    always_comb begin
        sum        = (first_i ? '0 : acc_q) + {{MAX_LOG2{1'b0}}, sample_i};
        sticky_now = or_i | (~first_i & sticky_q);
        result_o   = mode_avg_i ? DATA_W'(sum >> k_i) : sample_i;
        sticky_o   = sticky_now;

        acc_d    = acc_q;
        sticky_d = sticky_q;
        if (clear_i) begin
            acc_d    = '0;
            sticky_d = 1'b0;
        end else if (step_i) begin
            acc_d    = sum;
            sticky_d = sticky_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/adc_decimator.sv
`default_nettype none
// ============================================================================
// Module      : adc_decimator
// Description : Trigger-aligned 2^k decimator (pick or boxcar average) with
//               over-range tracking and emitted-sample counter.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_decimator
    import openadc_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int MAX_LOG2 = DECIM_MAX_LOG2,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    adc_data_i,
    input  logic                 adc_or_i,
    input  logic                 capture_go_i,
    input  logic [DECIM_K_W-1:0] decim_log2_i,
    input  logic                 mode_avg_i,
    output logic [DATA_W-1:0]    data_o,
    output logic                 or_o,
    output logic                 valid_o,
    output logic                 active_o,
    output logic [CNT_W-1:0]     sample_count_o
);
    localparam logic [DECIM_K_W-1:0] C_MAX_K   = DECIM_K_W'(MAX_LOG2);
    localparam logic [MAX_LOG2-1:0]  C_WIN_ONE = 1;
    localparam logic [CNT_W-1:0]     C_CNT_ONE = 1;

    decim_state_t          state_q, state_d;
    logic [DECIM_K_W-1:0]  k_q, k_d, k_sel, k_clamp;
    logic                  mode_q, mode_d, mode_sel;
    logic [MAX_LOG2-1:0]   win_q, win_d, last_idx;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  or_q, or_d, valid_q, valid_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  step, clear, first, last;
    logic [DATA_W-1:0]     result;
    logic                  sticky;

    assign k_clamp  = (decim_log2_i > C_MAX_K) ? C_MAX_K : decim_log2_i;
    assign first    = (win_q == '0);
    assign last_idx = ~({MAX_LOG2{1'b1}} << k_sel);
    assign last     = (win_q == last_idx);

    // The start-of-capture sample is consumed with the freshly latched config.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        mode_d   = mode_q;
        win_d    = win_q;
        data_d   = data_q;
        or_d     = or_q;
        valid_d  = 1'b0;
        count_d  = count_q;
        k_sel    = k_q;
        mode_sel = mode_q;
        step     = 1'b0;
        clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture_go_i) begin
                    state_d  = ST_RUN;
                    k_d      = k_clamp;
                    mode_d   = mode_avg_i;
                    k_sel    = k_clamp;
                    mode_sel = mode_avg_i;
                    count_d  = '0;
                    step     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!capture_go_i) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                    win_d   = '0;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            win_d = last ? '0 : win_q + C_WIN_ONE;
            if (last) begin
                valid_d = 1'b1;
                data_d  = result;
                or_d    = sticky;
                count_d = (count_d == '1) ? count_d : count_d + C_CNT_ONE;
            end
        end
    end

    decim_accum #(
        .DATA_W   (DATA_W),
        .MAX_LOG2 (MAX_LOG2)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear),
        .step_i     (step),
        .first_i    (first),
        .sample_i   (adc_data_i),
        .or_i       (adc_or_i),
        .k_i        (k_sel),
        .mode_avg_i (mode_sel),
        .result_o   (result),
        .sticky_o   (sticky)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            mode_q  <= 1'b0;
            win_q   <= '0;
            data_q  <= '0;
            or_q    <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            win_q   <= win_d;
            data_q  <= data_d;
            or_q    <= or_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data_o         = data_q;
    assign or_o           = or_q;
    assign valid_o        = valid_q;
    assign active_o       = (state_q == ST_RUN);
    assign sample_count_o = count_q;
endmodule
`default_nettype wire
